// File: rtl/axis_adc_decimator_pkg.sv
// Shared constants and types for the dual-lane ADC decimator.
//   - lane width and lane bit positions inside the 32-bit AXIS word
//   - default maximum log2 decimation ratio and resulting accumulator width
//   - 16-bit saturation limits
//   - FSM state encoding
package axis_adc_decimator_pkg;

    localparam int LANE_W             = 16;
    localparam int LANE_A_LSB         = 0;
    localparam int LANE_B_LSB         = LANE_A_LSB + LANE_W;
    localparam int MAX_LOG2_RATIO_DEF = 8;
    localparam int ACC_W              = LANE_W + 1 + MAX_LOG2_RATIO_DEF;

    localparam logic signed [LANE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [LANE_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/adc_lane_accum.sv
// One lane of the decimator: offset subtract, accumulate-and-dump, shift, saturate.
// Ports:
//   clk_i, rstn_i : clock, synchronous active-low reset
//   sample_i      : signed lane sample
//   offset_i      : signed DC offset subtracted from the sample
//   add_i         : fold the current difference into the accumulator
//   clr_i         : clear the accumulator (wins over add_i)
//   shift_i       : log2 block length used for the current result
//   result_o      : saturated (acc + diff) >>> shift_i, valid on the final sample
//   sat_o         : result_o was clipped
module adc_lane_accum
    import axis_adc_decimator_pkg::*;
#(
    parameter int DATA_WIDTH     = LANE_W,
    parameter int MAX_LOG2_RATIO = MAX_LOG2_RATIO_DEF
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic [DATA_WIDTH-1:0] offset_i,
    input  logic                  add_i,
    input  logic                  clr_i,
    input  logic [3:0]            shift_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  sat_o
);

    localparam int DIFF_W = DATA_WIDTH + 1;
    localparam int AW     = DATA_WIDTH + 1 + MAX_LOG2_RATIO;

    localparam logic [DATA_WIDTH-1:0] POS_LIM =
        (DATA_WIDTH == LANE_W) ? SAT_MAX : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_LIM =
        (DATA_WIDTH == LANE_W) ? SAT_MIN : {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DIFF_W-1:0] diff;
    logic signed [AW-1:0]     acc_q, acc_d, sum, shifted;
    logic [AW-DATA_WIDTH:0]   top_bits;

    // One extra bit keeps sample - offset exact over the full signed range.
    assign diff = $signed({sample_i[DATA_WIDTH-1], sample_i})
                - $signed({offset_i[DATA_WIDTH-1], offset_i});

    assign sum     = acc_q + $signed({{(AW-DIFF_W){diff[DIFF_W-1]}}, diff});
    assign shifted = sum >>> shift_i;

    // The result fits only if all bits from the lane sign bit upward agree.
    assign top_bits = shifted[AW-1:DATA_WIDTH-1];
    assign sat_o    = !((&top_bits) || (~|top_bits));
    assign result_o = !sat_o ? shifted[DATA_WIDTH-1:0]
                    : (shifted[AW-1] ? NEG_LIM : POS_LIM);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/axis_adc_decimator.sv
// Dual-lane block-averaging decimator between the ZMOD ADC AXIS driver and the
// line filter. Each block of 2^N samples per lane produces one averaged word.
// Ports:
//   aclk, rstn       : clock, synchronous active-low reset
//   s_axis_*         : input stream, tdata = {lane B, lane A}, signed 16-bit lanes
//   m_axis_*         : output stream, tdata = {avg B, avg A}
//   i4_log2_ratio    : decimation exponent N, clamped to MAX_LOG2_RATIO
//   i16_offset_a/b   : signed DC offsets per lane
//   i_enable         : run enable; dropping it discards the partial block
//   o_overflow       : sticky, set when any emitted lane saturated
//   o_dbg_state      : current FSM state
//
// Handshake: a beat transfers on any cycle where valid && ready. The master
// holds tdata stable while tvalid && !tready; the slave side is ready only
// when running and the output register is free or being drained this cycle.
module axis_adc_decimator
    import axis_adc_decimator_pkg::*;
#(
    parameter int DATA_WIDTH     = LANE_W,
    parameter int MAX_LOG2_RATIO = MAX_LOG2_RATIO_DEF
) (
    input  logic                    aclk,
    input  logic                    rstn,
    input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic [3:0]              i4_log2_ratio,
    input  logic [DATA_WIDTH-1:0]   i16_offset_a,
    input  logic [DATA_WIDTH-1:0]   i16_offset_b,
    input  logic                    i_enable,
    output logic                    o_overflow,
    output state_t                  o_dbg_state
);

    localparam int         CNT_W = MAX_LOG2_RATIO + 1;
    localparam logic [3:0] N_MAX = 4'(MAX_LOG2_RATIO);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, last_cnt;
    logic [3:0]              ratio_q, ratio_d, n_in, n_eff;
    logic                    m_valid_q, m_valid_d;
    logic [2*DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                    ovf_q, ovf_d;
    logic                    accept, final_smp, load, clr;
    logic [DATA_WIDTH-1:0]   res_a, res_b;
    logic                    sat_a, sat_b;

    assign n_in = (i4_log2_ratio > N_MAX) ? N_MAX : i4_log2_ratio;
    // The first sample of a block uses the live ratio, which is also what gets latched.
    assign n_eff    = (cnt_q == '0) ? n_in : ratio_q;
    assign last_cnt = (CNT_W'(1) << n_eff) - CNT_W'(1);

    assign s_axis_tready = i_enable && (state_q == S_ACC) && !(m_valid_q && !m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign final_smp     = (cnt_q == last_cnt);
    assign load          = accept && final_smp;
    assign clr           = (state_q == S_IDLE) || load;

    adc_lane_accum #(.DATA_WIDTH(DATA_WIDTH), .MAX_LOG2_RATIO(MAX_LOG2_RATIO)) u_lane_a (
        .clk_i    (aclk),
        .rstn_i   (rstn),
        .sample_i (s_axis_tdata[LANE_A_LSB +: DATA_WIDTH]),
        .offset_i (i16_offset_a),
        .add_i    (accept),
        .clr_i    (clr),
        .shift_i  (n_eff),
        .result_o (res_a),
        .sat_o    (sat_a)
    );

    adc_lane_accum #(.DATA_WIDTH(DATA_WIDTH), .MAX_LOG2_RATIO(MAX_LOG2_RATIO)) u_lane_b (
        .clk_i    (aclk),
        .rstn_i   (rstn),
        .sample_i (s_axis_tdata[LANE_B_LSB +: DATA_WIDTH]),
        .offset_i (i16_offset_b),
        .add_i    (accept),
        .clr_i    (clr),
        .shift_i  (n_eff),
        .result_o (res_b),
        .sat_o    (sat_b)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_enable) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (cnt_q == '0) begin
                        ratio_d = n_in;
                    end
                    cnt_d = final_smp ? '0 : cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        // A freshly completed block overrides a word drained in the same cycle.
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = {res_b, res_a};
            if (sat_a || sat_b) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ratio_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign o_overflow    = ovf_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Directed bench for axis_adc_decimator: one task per scenario, inline checks
// against hand-computed words, output beats collected by a negedge monitor.
module tb_axis_adc_decimator;
    import axis_adc_decimator_pkg::*;

    logic        aclk;
    logic        rstn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [3:0]  i4_log2_ratio;
    logic [15:0] i16_offset_a;
    logic [15:0] i16_offset_b;
    logic        i_enable;
    logic        o_overflow;
    state_t      o_dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] got_q[$];

    axis_adc_decimator dut (
        .aclk          (aclk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .i4_log2_ratio (i4_log2_ratio),
        .i16_offset_a  (i16_offset_a),
        .i16_offset_b  (i16_offset_b),
        .i_enable      (i_enable),
        .o_overflow    (o_overflow),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Output beats that complete a handshake at the next rising edge.
    always @(negedge aclk) begin
        if (rstn && m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Offer one sample and return 1 ns after the edge on which it was accepted.
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int guard;
        bit done;
        guard = 0;
        done  = 0;
        s_axis_tdata  = {b, a};
        s_axis_tvalid = 1'b1;
        while (!done && guard < 50) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                @(posedge aclk);
                #1;
                done = 1;
            end else begin
                guard++;
            end
        end
        s_axis_tvalid = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("FAIL push_timeout: tready low for %0d cycles, required 1", guard);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        step(3);
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_valid: got %b want 0", m_axis_tvalid); else pass_cnt++;
        total_cnt++; if (m_axis_tdata !== 32'h0) $display("FAIL rst_data: got %h want 00000000", m_axis_tdata); else pass_cnt++;
        total_cnt++; if (o_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", o_overflow); else pass_cnt++;
        total_cnt++; if (o_dbg_state !== S_IDLE) $display("FAIL rst_state: got %0d want %0d", o_dbg_state, S_IDLE); else pass_cnt++;
        total_cnt++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", s_axis_tready); else pass_cnt++;
        rstn = 1'b1;
        step(1);
    endtask

    task automatic test_block_average();
        got_q.delete();
        i4_log2_ratio = 4'd2;
        i16_offset_a  = 16'd0;
        i16_offset_b  = 16'd0;
        m_axis_tready = 1'b1;
        i_enable      = 1'b1;
        push(16'd100, 16'hFFFC);
        push(16'd200, 16'hFFFC);
        push(16'd300, 16'hFFFC);
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL avg_early_valid: got %b want 0", m_axis_tvalid); else pass_cnt++;
        push(16'd400, 16'hFFFC);
        total_cnt++; if (m_axis_tvalid !== 1'b1) $display("FAIL avg_valid: got %b want 1", m_axis_tvalid); else pass_cnt++;
        total_cnt++; if (m_axis_tdata !== 32'hFFFC_00FA) $display("FAIL avg_data: got %h want fffc00fa", m_axis_tdata); else pass_cnt++;
        step(4);
        total_cnt++; if (got_q.size() !== 1) $display("FAIL avg_count: got %0d want 1", got_q.size()); else pass_cnt++;
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL avg_valid_clear: got %b want 0", m_axis_tvalid); else pass_cnt++;
    endtask

    task automatic test_floor_offset();
        got_q.delete();
        i4_log2_ratio = 4'd1;
        i16_offset_a  = 16'd10;
        push(16'hFFFF, 16'd0);
        push(16'hFFFE, 16'd0);
        total_cnt++; if (m_axis_tdata !== 32'h0000_FFF4) $display("FAIL floor_data: got %h want 0000fff4", m_axis_tdata); else pass_cnt++;
        total_cnt++; if (o_overflow !== 1'b0) $display("FAIL floor_ovf: got %b want 0", o_overflow); else pass_cnt++;
        step(2);
        total_cnt++; if (got_q.size() !== 1) $display("FAIL floor_count: got %0d want 1", got_q.size()); else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [31:0] exp_w;
        got_q.delete();
        i4_log2_ratio = 4'd0;
        i16_offset_a  = 16'h8000;
        push(16'd8191, 16'd0);
        total_cnt++; if (m_axis_tdata !== 32'h0000_7FFF) $display("FAIL sat_pos_data: got %h want 00007fff", m_axis_tdata); else pass_cnt++;
        total_cnt++; if (o_overflow !== 1'b1) $display("FAIL sat_pos_ovf: got %b want 1", o_overflow); else pass_cnt++;
        i16_offset_a = 16'h7FFF;
        push(16'h8000, 16'd0);
        total_cnt++; if (m_axis_tdata !== 32'h0000_8000) $display("FAIL sat_neg_data: got %h want 00008000", m_axis_tdata); else pass_cnt++;
        i16_offset_a = 16'd0;
        for (int i = 1; i <= 10; i++) push(16'(i * 100), 16'(-i));
        step(3);
        total_cnt++; if (o_overflow !== 1'b1) $display("FAIL sat_sticky: got %b want 1", o_overflow); else pass_cnt++;
        total_cnt++; if (got_q.size() !== 12) $display("FAIL sat_count: got %0d want 12", got_q.size()); else pass_cnt++;
        if (got_q.size() == 12) begin
            for (int i = 1; i <= 10; i++) begin
                exp_w = {16'(-i), 16'(i * 100)};
                total_cnt++;
                if (got_q[i+1] !== exp_w) $display("FAIL sat_after_%0d: got %h want %h", i, got_q[i+1], exp_w);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        got_q.delete();
        i4_log2_ratio = 4'd0;
        m_axis_tready = 1'b0;
        push(16'd1, 16'd11);
        total_cnt++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h000B_0001)
            $display("FAIL bp_first: got %b/%h want 1/000b0001", m_axis_tvalid, m_axis_tdata); else pass_cnt++;
        s_axis_tdata  = 32'h0016_FFFB;
        s_axis_tvalid = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            total_cnt++; if (s_axis_tready !== 1'b0) $display("FAIL bp_tready: got %b want 0", s_axis_tready); else pass_cnt++;
            total_cnt++; if (m_axis_tdata !== 32'h000B_0001) $display("FAIL bp_hold: got %h want 000b0001", m_axis_tdata); else pass_cnt++;
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        push(16'hFFFB, 16'h0016);
        total_cnt++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0016_FFFB)
            $display("FAIL bp_second: got %b/%h want 1/0016fffb", m_axis_tvalid, m_axis_tdata); else pass_cnt++;
        push(16'h7FFF, 16'h8000);
        step(3);
        total_cnt++; if (got_q.size() !== 3) $display("FAIL bp_count: got %0d want 3", got_q.size()); else pass_cnt++;
        if (got_q.size() == 3) begin
            total_cnt++; if (got_q[0] !== 32'h000B_0001) $display("FAIL bp_out0: got %h want 000b0001", got_q[0]); else pass_cnt++;
            total_cnt++; if (got_q[1] !== 32'h0016_FFFB) $display("FAIL bp_out1: got %h want 0016fffb", got_q[1]); else pass_cnt++;
            total_cnt++; if (got_q[2] !== 32'h8000_7FFF) $display("FAIL bp_out2: got %h want 80007fff", got_q[2]); else pass_cnt++;
        end
    endtask

    task automatic test_ratio_change();
        got_q.delete();
        i4_log2_ratio = 4'd2;
        push(16'd4, 16'd0);
        push(16'd8, 16'd0);
        i4_log2_ratio = 4'd0;
        push(16'd12, 16'd0);
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL ratio_midblock: got valid %b want 0", m_axis_tvalid); else pass_cnt++;
        push(16'd16, 16'd0);
        total_cnt++; if (m_axis_tdata !== 32'h0000_000A) $display("FAIL ratio_block: got %h want 0000000a", m_axis_tdata); else pass_cnt++;
        push(16'd5, 16'd0);
        total_cnt++; if (m_axis_tdata !== 32'h0000_0005) $display("FAIL ratio_n0_a: got %h want 00000005", m_axis_tdata); else pass_cnt++;
        push(16'd6, 16'd0);
        total_cnt++; if (m_axis_tdata !== 32'h0000_0006) $display("FAIL ratio_n0_b: got %h want 00000006", m_axis_tdata); else pass_cnt++;
        step(3);
        total_cnt++; if (got_q.size() !== 3) $display("FAIL ratio_count: got %0d want 3", got_q.size()); else pass_cnt++;

        got_q.delete();
        i4_log2_ratio = 4'd15;
        for (int i = 0; i < 255; i++) push(16'(i), 16'(-i));
        total_cnt++; if (got_q.size() !== 0 || m_axis_tvalid !== 1'b0)
            $display("FAIL clamp_early: got %0d beats valid %b want 0 beats valid 0", got_q.size(), m_axis_tvalid); else pass_cnt++;
        push(16'd255, 16'(-255));
        total_cnt++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hFF80_007F)
            $display("FAIL clamp_data: got %b/%h want 1/ff80007f", m_axis_tvalid, m_axis_tdata); else pass_cnt++;
        step(2);
        total_cnt++; if (got_q.size() !== 1) $display("FAIL clamp_count: got %0d want 1", got_q.size()); else pass_cnt++;
    endtask

    task automatic test_enable_reset();
        got_q.delete();
        i4_log2_ratio = 4'd3;
        for (int i = 0; i < 5; i++) push(16'd100, 16'd100);
        i_enable = 1'b0;
        @(negedge aclk);
        total_cnt++; if (s_axis_tready !== 1'b0) $display("FAIL en_tready: got %b want 0", s_axis_tready); else pass_cnt++;
        @(posedge aclk);
        #1;
        total_cnt++; if (o_dbg_state !== S_IDLE) $display("FAIL en_state: got %0d want %0d", o_dbg_state, S_IDLE); else pass_cnt++;
        step(1);
        i_enable = 1'b1;
        for (int i = 0; i < 8; i++) push(16'd7, 16'd7);
        total_cnt++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0007_0007)
            $display("FAIL en_resume: got %b/%h want 1/00070007", m_axis_tvalid, m_axis_tdata); else pass_cnt++;
        step(2);
        total_cnt++; if (got_q.size() !== 1) $display("FAIL en_count: got %0d want 1", got_q.size()); else pass_cnt++;

        for (int i = 0; i < 3; i++) push(16'd1000, 16'd1000);
        total_cnt++; if (o_overflow !== 1'b1) $display("FAIL prerst_ovf: got %b want 1", o_overflow); else pass_cnt++;
        rstn = 1'b0;
        step(1);
        total_cnt++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", m_axis_tvalid); else pass_cnt++;
        total_cnt++; if (m_axis_tdata !== 32'h0) $display("FAIL midrst_data: got %h want 00000000", m_axis_tdata); else pass_cnt++;
        total_cnt++; if (o_overflow !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", o_overflow); else pass_cnt++;
        total_cnt++; if (o_dbg_state !== S_IDLE) $display("FAIL midrst_state: got %0d want %0d", o_dbg_state, S_IDLE); else pass_cnt++;
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) push(16'd3, 16'hFFFE);
        total_cnt++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hFFFE_0003)
            $display("FAIL postrst_block: got %b/%h want 1/fffe0003", m_axis_tvalid, m_axis_tdata); else pass_cnt++;
        step(2);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rstn          = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        i4_log2_ratio = 4'd0;
        i16_offset_a  = 16'd0;
        i16_offset_b  = 16'd0;
        i_enable      = 1'b0;
        #1;
        test_reset();
        test_block_average();
        test_floor_offset();
        test_saturation();
        test_backpressure();
        test_ratio_change();
        test_enable_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
